sr04_ctrl: RTL and testbench



---
 rtl/sr04_ctrl.sv | 157 +++++++++++++++
 tb/tb_sr04_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sr04_ctrl.sv
// sr04_ctrl: HC-SR04 ultrasonic range-finder controller.
// A one-cycle start pulse launches one measurement: a TRIG_US-wide trig
// pulse, a timed wait for echo, then the echo high time is measured and
// converted to whole centimetres (floor(echo_us / US_PER_CM)).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   one-cycle launch pulse (ignored unless idle)
//   echo        in   sensor echo, asynchronous to clk
//   trig        out  sensor trigger pulse (registered)
//   distance    out  last valid distance in cm, held between measurements
//   dist_valid  out  one-cycle strobe when distance updates
//   busy        out  high whenever a measurement is in progress
//   timeout_err out  sticky error, cleared by the next valid measurement
module sr04_ctrl #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TRIG_US     = 10,
    parameter int US_PER_CM   = 58,
    parameter int WAIT_TO_US  = 30_000,
    parameter int MAX_CM      = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       echo,
    output logic       trig,
    output logic [8:0] distance,
    output logic       dist_valid,
    output logic       busy,
    output logic       timeout_err
);
    localparam int CLKS_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int PW          = $clog2(CLKS_PER_US);
    localparam int UMAX        = (WAIT_TO_US > TRIG_US) ? WAIT_TO_US : TRIG_US;
    localparam int UW          = $clog2(UMAX + 1);
    localparam int SW          = $clog2(US_PER_CM + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_US - 1);
    localparam logic [UW-1:0] TRIG_LAST  = UW'(TRIG_US - 1);
    localparam logic [UW-1:0] WAIT_LAST  = UW'(WAIT_TO_US - 1);
    localparam logic [SW-1:0] SUB_LAST   = SW'(US_PER_CM - 1);
    localparam logic [8:0]    MAX_CM_V   = 9'(MAX_CM);

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          echo_m_q, echo_s_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [UW-1:0] us_cnt_q, us_cnt_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [8:0]    cm_cnt_q, cm_cnt_d;
    logic          trig_q, trig_d;
    logic          busy_q, busy_d;
    logic          dv_q, dv_d;
    logic          to_q, to_d;
    logic [8:0]    dist_q, dist_d;
    logic          us_tick, cm_wrap, state_chg;

    assign us_tick = (presc_q == PRESC_LAST);
    assign cm_wrap = us_tick && (sub_q == SUB_LAST);

    // State register plus all datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            echo_m_q <= 1'b0;
            echo_s_q <= 1'b0;
            presc_q  <= '0;
            us_cnt_q <= '0;
            sub_q    <= '0;
            cm_cnt_q <= '0;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
            dv_q     <= 1'b0;
            to_q     <= 1'b0;
            dist_q   <= '0;
        end else begin
            state_q  <= state_d;
            echo_m_q <= echo;
            echo_s_q <= echo_m_q;
            presc_q  <= presc_d;
            us_cnt_q <= us_cnt_d;
            sub_q    <= sub_d;
            cm_cnt_q <= cm_cnt_d;
            trig_q   <= trig_d;
            busy_q   <= busy_d;
            dv_q     <= dv_d;
            to_q     <= to_d;
            dist_q   <= dist_d;
        end
    end

    // Next-state logic. start is only honoured once the registered busy
    // has also dropped, so a start coinciding with dist_valid is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && !busy_q) state_d = S_TRIG;
            S_TRIG: if (us_tick && us_cnt_q == TRIG_LAST) state_d = S_WAIT;
            S_WAIT: begin
                if (echo_s_q)                                  state_d = S_MEAS;
                else if (us_tick && us_cnt_q == WAIT_LAST)     state_d = S_IDLE;
            end
            S_MEAS: begin
                // Echo fall wins over overflow on the same cycle; DONE clamps.
                if (!echo_s_q)                                 state_d = S_DONE;
                else if (cm_wrap && cm_cnt_q == MAX_CM_V)      state_d = S_IDLE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Timebase: prescaler and us counter restart on every state change so
    // each state's timing begins on an exact microsecond boundary.
    always_comb begin
        state_chg = (state_d != state_q);
        presc_d   = (state_chg || us_tick) ? '0 : presc_q + 1'b1;
        us_cnt_d  = us_cnt_q;
        if (state_chg)
            us_cnt_d = '0;
        else if (us_tick && (state_q == S_TRIG || state_q == S_WAIT))
            us_cnt_d = us_cnt_q + 1'b1;

        sub_d    = sub_q;
        cm_cnt_d = cm_cnt_q;
        if (state_q != S_MEAS && state_d == S_MEAS) begin
            sub_d    = '0;
            cm_cnt_d = '0;
        end else if (state_q == S_MEAS && us_tick) begin
            sub_d = cm_wrap ? '0 : sub_q + 1'b1;
            if (cm_wrap) cm_cnt_d = cm_cnt_q + 9'd1;
        end
    end

    // Registered output decode.
    always_comb begin
        trig_d = (state_q == S_TRIG);
        busy_d = (state_q != S_IDLE);
        dv_d   = (state_q == S_DONE);
        dist_d = dist_q;
        to_d   = to_q;
        if (state_q == S_DONE) begin
            dist_d = (cm_cnt_q > MAX_CM_V) ? MAX_CM_V : cm_cnt_q;
            to_d   = 1'b0;
        end else if ((state_q == S_WAIT || state_q == S_MEAS) && state_d == S_IDLE) begin
            to_d   = 1'b1;
        end
    end

    assign trig        = trig_q;
    assign busy        = busy_q;
    assign dist_valid  = dv_q;
    assign timeout_err = to_q;
    assign distance    = dist_q;
endmodule

// File: tb/tb_sr04_ctrl.sv
// Bench for sr04_ctrl, run with a scaled timebase (2 clocks/us, 4 us/cm,
// 300 us echo wait, 20 cm limit) so every scenario stays short.
`timescale 1ns/1ps
module tb_sr04_ctrl;
    localparam int CPU  = 2;
    localparam int TRUS = 10;
    localparam int UPC  = 4;
    localparam int WTO  = 300;
    localparam int MAXC = 20;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, echo = 1'b0;
    logic       trig, dist_valid, busy, timeout_err;
    logic [8:0] distance;

    sr04_ctrl #(
        .CLK_FREQ_HZ(CPU * 1_000_000), .TRIG_US(TRUS), .US_PER_CM(UPC),
        .WAIT_TO_US(WTO), .MAX_CM(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .echo(echo), .trig(trig),
        .distance(distance), .dist_valid(dist_valid), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int dv_cnt = 0, dv_last = 0, trig_rises = 0;
    logic trig_prev = 1'b0;

    always @(negedge clk) begin
        if (dist_valid) begin
            dv_cnt  <= dv_cnt + 1;
            dv_last <= int'(distance);
        end
        if (trig && !trig_prev) trig_rises <= trig_rises + 1;
        trig_prev <= trig;
    end

    typedef struct {
        int h_us;     // echo high time in us (0 = no echo)
        int dly_us;   // trig fall to echo rise
        int early;    // raise echo while trig is still high
        int extra;    // extra start pulses while busy / in dist_valid cycle
        int exp_valid;
        int exp_dist;
        int exp_to;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_meas(input vec_t v, output int gv, output int gd,
                            output int gt, output int tw, output int tr,
                            output int wc);
        int d0, r0, n;
        d0 = dv_cnt;
        r0 = trig_rises;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!trig && n < 10) begin @(negedge clk); n++; end
        tw = 0;
        while (trig && tw < 5000) begin
            start = (v.extra != 0 && tw == 3);
            if (v.early != 0 && tw == 2) echo = 1'b1;
            @(negedge clk);
            tw++;
        end
        start = 1'b0;
        wc = 0;
        if (v.h_us > 0) begin
            if (v.early == 0) begin
                repeat (v.dly_us * CPU) begin @(negedge clk); wc++; end
                echo = 1'b1;
            end
            for (int i = 0; i < v.h_us * CPU; i++) begin
                start = (v.extra != 0 && i == v.h_us);
                @(negedge clk);
                wc++;
            end
            start = 1'b0;
            echo  = 1'b0;
        end
        while (busy && wc < 3000) begin
            start = (v.extra != 0 && dist_valid);
            @(negedge clk);
            wc++;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        gv = dv_cnt - d0;
        gd = dv_last;
        gt = int'(timeout_err);
        tr = trig_rises - r0;
        chk("idle_after", int'(busy), 0);
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        int gv, gd, gt, tw, tr, wc;
        run_meas(v, gv, gd, gt, tw, tr, wc);
        chk({tag, ".trig_width"}, tw, TRUS * CPU);
        chk({tag, ".trig_count"}, tr, 1);
        chk({tag, ".valid"}, gv, v.exp_valid);
        chk({tag, ".distance"}, int'(distance), v.exp_dist);
        if (v.exp_valid != 0) chk({tag, ".strobe_dist"}, gd, v.exp_dist);
        chk({tag, ".timeout"}, gt, v.exp_to);
        if (v.h_us == 0) chk({tag, ".to_time"}, int'(wc >= WTO*CPU-2 && wc <= WTO*CPU+2), 1);
    endtask

    vec_t vecs[10];
    int   model_dist;

    initial begin
        vecs[0] = '{42,  20, 0, 0, 1, 10, 0};  // single measurement
        vecs[1] = '{82,  10, 0, 1, 1, 20, 0};  // top of range, starts while busy
        vecs[2] = '{86,  10, 0, 0, 0, 20, 1};  // echo past range: error, held
        vecs[3] = '{0,   0,  0, 0, 0, 20, 1};  // no echo
        vecs[4] = '{22,  40, 0, 0, 1, 5,  0};  // good echo clears error
        vecs[5] = '{3,   0,  0, 0, 1, 0,  0};  // sub-cm echo -> 0
        vecs[6] = '{0,   0,  0, 0, 0, 0,  1};
        vecs[7] = '{5,  297, 0, 0, 1, 1,  0};  // echo just before wait limit
        vecs[8] = '{42,  0,  1, 1, 1, 10, 0};  // stale echo already high
        vecs[9] = '{83,  0,  0, 0, 1, 20, 0};

        // Reset state, asserted asynchronously.
        #1 rst = 1'b1;
        #2;
        chk("rst.trig", int'(trig), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.dv", int'(dist_valid), 0);
        chk("rst.dist", int'(distance), 0);
        chk("rst.to", int'(timeout_err), 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 10; k++)
            check_vec($sformatf("vec%0d", k), vecs[k]);
        model_dist = vecs[9].exp_dist;

        // Reset in the middle of MEASURE.
        begin
            int n;
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            n = 0;
            while (!trig && n < 10) begin @(negedge clk); n++; end
            while (trig && n < 100) begin @(negedge clk); n++; end
            echo = 1'b1;
            repeat (40) @(negedge clk);
            chk("pre_rst.busy", int'(busy), 1);
            #2 rst = 1'b1;
            #1;
            chk("mid_rst.trig", int'(trig), 0);
            chk("mid_rst.busy", int'(busy), 0);
            chk("mid_rst.dv", int'(dist_valid), 0);
            chk("mid_rst.dist", int'(distance), 0);
            @(negedge clk);
            echo = 1'b0;
            rst  = 1'b0;
            repeat (2) @(negedge clk);
            model_dist = 0;
            check_vec("after_rst", '{22, 15, 0, 0, 1, 5, 0});
            model_dist = 5;
        end

        // Randomized measurements against an arithmetic model.
        for (int k = 0; k < 15; k++) begin
            vec_t v;
            int   h, cm;
            h = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 95));
            if (h % UPC == 0 && h != 0) h = h - 1;
            v.h_us   = h;
            v.dly_us = int'($urandom_range(0, 250));
            v.early  = 0;
            v.extra  = int'($urandom_range(0, 1));
            cm = h / UPC;
            if (h == 0 || cm > MAXC) begin
                v.extra     = 0;
                v.exp_valid = 0;
                v.exp_to    = 1;
            end else begin
                v.exp_valid = 1;
                v.exp_to    = 0;
                model_dist  = cm;
            end
            v.exp_dist = model_dist;
            check_vec($sformatf("rnd%0d_h%0d", k, h), v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
